// File: rtl/pixel_stream_pkg.sv
// pixel_stream shared types and constants.
// FSM state enum, underflow fill colour, counter width.
package pixel_stream_pkg;

  typedef enum logic [1:0] {
    FILL,
    SOF_WAIT,
    STREAM
  } state_t;

  localparam logic [23:0] UNDERFLOW_RGB = 24'hFF00FF;
  localparam int          UFCNT_W       = 16;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level.
// Ports: clk, rst (async high), d (async in), q (synced out).
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift d in at bit 0; the cast drops the oldest bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= STAGES'({ff, d});
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pixel_stream.sv
// Frame-buffer FIFO consumer in the pixel clock domain.
// Prefills, aligns to vsync, pops one pixel per active cycle.
// Ports:
//   pixel_clk, pixel_rst      clock, async active-high reset
//   blank_in, vs_in           timing generator (vs active-low)
//   fifo_rdata, fifo_rempty   FWFT FIFO read side
//   fifo_walmost_full         write-domain almost-full (async)
//   clr_status                clears sticky flags
//   fifo_read                 combinational pop
//   rgb, blank_out            registered video out
//   frame_done                pulse after last frame pixel
//   underflow, sync_err       sticky status
//   underflow_cnt             only with PIXEL_STREAM_UFCNT_EN
module pixel_stream
  import pixel_stream_pkg::*;
#(
  parameter int HDISP       = 800,
  parameter int VDISP       = 480,
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  pixel_clk,
  input  logic                  pixel_rst,
  input  logic                  blank_in,
  input  logic                  vs_in,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_rempty,
  input  logic                  fifo_walmost_full,
  input  logic                  clr_status,
  output logic                  fifo_read,
  output logic [DATA_WIDTH-1:0] rgb,
  output logic                  blank_out,
  output logic                  frame_done,
  output logic                  underflow,
  output logic                  sync_err
`ifdef PIXEL_STREAM_UFCNT_EN
  ,
  output logic [UFCNT_W-1:0]    underflow_cnt
`endif
);

  localparam int TOTAL = HDISP * VDISP;
  localparam int CNT_W = $clog2(TOTAL);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TOTAL - 1);
  localparam logic [DATA_WIDTH-1:0] UF_PIX =
    DATA_WIDTH'(UNDERFLOW_RGB);

  state_t           state;
  logic             wam_sync;
  logic             vs_prev;
  logic [CNT_W-1:0] pix_cnt;

  logic streaming;
  logic active;
  logic pop;
  logic starve;
  logic vs_rise;
  logic last_pix;
  logic frame_slip;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_wam_sync (
    .clk (pixel_clk),
    .rst (pixel_rst),
    .d   (fifo_walmost_full),
    .q   (wam_sync)
  );

  assign streaming = (state == STREAM);
  assign active    = streaming & blank_in;
  assign pop       = active & ~fifo_rempty;
  assign starve    = active & fifo_rempty;
  // vs_in is active-low: the rising edge ends the sync pulse.
  assign vs_rise   = vs_in & ~vs_prev;
  assign last_pix  = (pix_cnt == LAST);
  assign frame_slip =
    streaming & vs_rise & (pix_cnt != '0);

  assign fifo_read = pop;

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state      <= FILL;
      vs_prev    <= 1'b1;
      pix_cnt    <= '0;
      rgb        <= '0;
      blank_out  <= 1'b0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      vs_prev    <= vs_in;
      blank_out  <= blank_in;
      frame_done <= 1'b0;

      unique case (state)
        FILL: begin
          if (wam_sync) state <= SOF_WAIT;
        end
        SOF_WAIT: begin
          if (vs_rise) begin
            state   <= STREAM;
            pix_cnt <= '0;
          end
        end
        STREAM: begin
          // A frame start always re-aligns the count;
          // starved pixels still advance it.
          if (vs_rise) begin
            pix_cnt <= '0;
          end else if (active) begin
            if (last_pix) begin
              pix_cnt    <= '0;
              frame_done <= 1'b1;
            end else begin
              pix_cnt <= pix_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= FILL;
      endcase

      unique case (1'b1)
        pop:     rgb <= fifo_rdata;
        starve:  rgb <= UF_PIX;
        default: rgb <= '0;
      endcase

      // New events win over a same-cycle clear.
      underflow <= starve |
                   (underflow & ~clr_status);
      sync_err  <= frame_slip |
                   (sync_err & ~clr_status);
    end
  end

`ifdef PIXEL_STREAM_UFCNT_EN
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      underflow_cnt <= '0;
    end else if (starve) begin
      if (clr_status) begin
        underflow_cnt <= UFCNT_W'(1);
      end else if (underflow_cnt != '1) begin
        underflow_cnt <= underflow_cnt + UFCNT_W'(1);
      end
    end else if (clr_status) begin
      underflow_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_stream.sv
// Self-checking bench for pixel_stream with a small frame.
// Bench acts as FIFO and timing generator; model predicts outputs.
module tb_pixel_stream;
  import pixel_stream_pkg::*;

  localparam int HD    = 8;
  localparam int VD    = 4;
  localparam int DW    = 24;
  localparam int SS    = 2;
  localparam int TOTAL = HD * VD;

  logic          pixel_clk = 1'b0;
  logic          pixel_rst;
  logic          blank_in;
  logic          vs_in;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rempty;
  logic          fifo_walmost_full;
  logic          clr_status;
  logic          fifo_read;
  logic [DW-1:0] rgb;
  logic          blank_out;
  logic          frame_done;
  logic          underflow;
  logic          sync_err;
`ifdef PIXEL_STREAM_UFCNT_EN
  logic [UFCNT_W-1:0] underflow_cnt;
`endif

  always #5 pixel_clk = ~pixel_clk;

  pixel_stream #(
    .HDISP       (HD),
    .VDISP       (VD),
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (SS)
  ) dut (
    .pixel_clk         (pixel_clk),
    .pixel_rst         (pixel_rst),
    .blank_in          (blank_in),
    .vs_in             (vs_in),
    .fifo_rdata        (fifo_rdata),
    .fifo_rempty       (fifo_rempty),
    .fifo_walmost_full (fifo_walmost_full),
    .clr_status        (clr_status),
    .fifo_read         (fifo_read),
    .rgb               (rgb),
    .blank_out         (blank_out),
    .frame_done        (frame_done),
    .underflow         (underflow),
    .sync_err          (sync_err)
`ifdef PIXEL_STREAM_UFCNT_EN
    ,
    .underflow_cnt     (underflow_cnt)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] next_word;

  // Model: phase 0 = prefill, 1 = wait frame, 2 = streaming.
  int      m_phase;
  int      m_cnt;
  int      m_wam_run;
  bit      m_vs_last;
  bit      m_uf;
  bit      m_se;
  int      m_ufcnt;
  logic [DW-1:0] exp_rgb;
  logic    exp_read;
  logic    exp_blank;
  logic    exp_fd;
  logic    obs_read;
  logic [DW+4:0] obs_v;
  logic [DW+4:0] exp_v;

  task automatic push_words(input int n);
    repeat (n) begin
      fifo_q.push_back(next_word);
      model_q.push_back(next_word);
      next_word = next_word + 1'b1;
    end
  endtask

  function automatic void model_reset();
    m_phase   = 0;
    m_cnt     = 0;
    m_wam_run = 0;
    m_vs_last = 1'b1;
    m_uf      = 1'b0;
    m_se      = 1'b0;
    m_ufcnt   = 0;
    exp_rgb   = '0;
    exp_read  = 1'b0;
    exp_blank = 1'b0;
    exp_fd    = 1'b0;
  endfunction

  // One pixel clock: drive, predict, advance, capture.
  task automatic step(input logic b, input logic vs,
                      input logic fe, input logic clr);
    bit vs_rise;
    bit have;
    bit uf_ev;
    bit se_ev;
    blank_in   = b;
    vs_in      = vs;
    clr_status = clr;
    if (fifo_q.size() < 4) push_words(16);
    fifo_rempty = fe;
    fifo_rdata  = fifo_q[0];
    #1;
    obs_read = fifo_read;

    have    = !fe;
    vs_rise = vs && !m_vs_last;
    m_vs_last = vs;
    uf_ev   = 1'b0;
    se_ev   = 1'b0;
    exp_read  = (m_phase == 2) && b && have;
    exp_blank = b;
    exp_fd    = 1'b0;
    exp_rgb   = '0;
    if (m_phase == 0) begin
      if (m_wam_run >= SS) m_phase = 1;
    end else if (m_phase == 1) begin
      if (vs_rise) begin
        m_phase = 2;
        m_cnt   = 0;
      end
    end else begin
      if (b) begin
        if (have) exp_rgb = model_q.pop_front();
        else begin
          exp_rgb = 24'hFF00FF;
          uf_ev   = 1'b1;
        end
      end
      if (vs_rise) begin
        se_ev = (m_cnt != 0);
        m_cnt = 0;
      end else if (b) begin
        m_cnt++;
        if (m_cnt == TOTAL) begin
          m_cnt  = 0;
          exp_fd = 1'b1;
        end
      end
    end
    m_uf = uf_ev || (m_uf && !clr);
    m_se = se_ev || (m_se && !clr);
    if (uf_ev) m_ufcnt = clr ? 1 :
                         (m_ufcnt < 65535 ? m_ufcnt + 1 : m_ufcnt);
    else if (clr) m_ufcnt = 0;
    if (fifo_walmost_full) begin
      if (m_wam_run < 100) m_wam_run++;
    end else begin
      m_wam_run = 0;
    end

    @(posedge pixel_clk);
    if (obs_read) void'(fifo_q.pop_front());
    #1;
    obs_v = {obs_read, rgb, blank_out,
             frame_done, underflow, sync_err};
    exp_v = {exp_read, exp_rgb, exp_blank,
             exp_fd, m_uf, m_se};
  endtask

  task automatic test_reset();
    pixel_rst         = 1'b1;
    blank_in          = 1'b1;
    vs_in             = 1'b1;
    fifo_walmost_full = 1'b0;
    clr_status        = 1'b0;
    fifo_rempty       = 1'b0;
    fifo_rdata        = '1;
    repeat (2) @(posedge pixel_clk);
    #1;
    n_assert++;
    if ({fifo_read, rgb, blank_out, frame_done,
         underflow, sync_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_vals got %h want 0",
               {fifo_read, rgb, blank_out, frame_done,
                underflow, sync_err});
    end
    pixel_rst = 1'b0;
    model_reset();
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom), 1'($urandom), 1'b0, 1'b0);
      n_assert++;
      if (obs_v !== exp_v || obs_read !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_idle cyc=%0d got %h want %h",
                 i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_align();
    fifo_walmost_full = 1'b1;
    // vs edge while still synchronizing must be ignored.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      n_assert++;
      if (obs_v !== exp_v || obs_read !== 1'b0) begin
        n_fail++;
        $display("FAIL early_vs cyc=%0d got %h want %h",
                 i, obs_v, exp_v);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    n_assert++;
    if (obs_v !== exp_v) begin
      n_fail++;
      $display("FAIL sof got %h want %h", obs_v, exp_v);
    end
  endtask

  task automatic test_frame();
    int fd_cnt = 0;
    for (int l = 0; l < VD; l++) begin
      for (int p = 0; p < HD; p++) begin
        repeat ($urandom_range(0, 2)) begin
          step(1'b0, 1'b1, 1'b0, 1'b0);
          if (frame_done) fd_cnt++;
          n_assert++;
          if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL frame_gap got %h want %h",
                     obs_v, exp_v);
          end
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        if (frame_done) fd_cnt++;
        n_assert++;
        if (obs_v !== exp_v || obs_read !== 1'b1) begin
          n_fail++;
          $display("FAIL frame_pix l=%0d p=%0d got %h want %h",
                   l, p, obs_v, exp_v);
        end
      end
      repeat (3) begin
        step(1'b0, 1'b1, 1'b0, 1'b0);
        if (frame_done) fd_cnt++;
        n_assert++;
        if (obs_v !== exp_v) begin
          n_fail++;
          $display("FAIL frame_hbl got %h want %h",
                   obs_v, exp_v);
        end
      end
    end
    n_assert++;
    if (fd_cnt !== 1) begin
      n_fail++;
      $display("FAIL frame_done_cnt got %0d want 1", fd_cnt);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    n_assert++;
    if (obs_v !== exp_v || sync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL aligned_vs got %h want %h", obs_v, exp_v);
    end
  endtask

  task automatic test_underflow();
    int uf_pix = 0;
    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, (i >= 3 && i < 6), 1'b0);
      if (rgb === 24'hFF00FF) uf_pix++;
      n_assert++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL uf_seq i=%0d got %h want %h",
                 i, obs_v, exp_v);
      end
    end
    n_assert++;
    if (uf_pix !== 3 || underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL uf_pix got %0d/%b want 3/1",
               uf_pix, underflow);
    end
`ifdef PIXEL_STREAM_UFCNT_EN
    n_assert++;
    if (underflow_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL uf_cnt got %0d want 3", underflow_cnt);
    end
`endif
    step(1'b0, 1'b1, 1'b0, 1'b1);
    n_assert++;
    if (obs_v !== exp_v || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL uf_clr got %h want %h", obs_v, exp_v);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1);
    n_assert++;
    if (obs_v !== exp_v || underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL uf_clr_race got %h want %h",
               obs_v, exp_v);
    end
`ifdef PIXEL_STREAM_UFCNT_EN
    n_assert++;
    if (underflow_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL uf_cnt_race got %0d want 1",
               underflow_cnt);
    end
`endif
    step(1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_sync_err();
    int fd_cnt = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    n_assert++;
    if (obs_v !== exp_v || sync_err !== 1'b1) begin
      n_fail++;
      $display("FAIL sync_err got %h want %h", obs_v, exp_v);
    end
    for (int i = 0; i < TOTAL + 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (frame_done) fd_cnt++;
      n_assert++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL realign i=%0d got %h want %h",
                 i, obs_v, exp_v);
      end
    end
    n_assert++;
    if (fd_cnt !== 1) begin
      n_fail++;
      $display("FAIL realign_fd got %0d want 1", fd_cnt);
    end
    step(1'b0, 1'b1, 1'b0, 1'b1);
    n_assert++;
    if (obs_v !== exp_v || sync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL se_clr got %h want %h", obs_v, exp_v);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    blank_in = 1'b1;
    #2;
    pixel_rst = 1'b1;
    #1;
    n_assert++;
    if ({fifo_read, rgb, blank_out, frame_done,
         underflow, sync_err} !== '0) begin
      n_fail++;
      $display("FAIL mid_rst got %h want 0",
               {fifo_read, rgb, blank_out, frame_done,
                underflow, sync_err});
    end
    @(posedge pixel_clk);
    #1;
    pixel_rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      n_assert++;
      if (obs_v !== exp_v || obs_read !== 1'b0) begin
        n_fail++;
        $display("FAIL post_rst i=%0d got %h want %h",
                 i, obs_v, exp_v);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    n_assert++;
    if (obs_v !== exp_v || obs_read !== 1'b1) begin
      n_fail++;
      $display("FAIL resume got %h want %h", obs_v, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    bit vs_pend = 1'b0;
    logic b;
    logic vs;
    for (int i = 0; i < 2000; i++) begin
      b  = (($urandom % 4) != 0);
      vs = 1'b1;
      if (vs_pend) begin
        b       = 1'b0;
        vs_pend = 1'b0;
      end else if (!b && ($urandom % 40) == 0) begin
        vs      = 1'b0;
        vs_pend = 1'b1;
      end
      step(b, vs, (($urandom % 16) == 0),
           (($urandom % 32) == 0));
      n_assert++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL random cyc=%0d got %h want %h",
                 i, obs_v, exp_v);
      end
`ifdef PIXEL_STREAM_UFCNT_EN
      n_assert++;
      if (underflow_cnt !== UFCNT_W'(m_ufcnt)) begin
        n_fail++;
        $display("FAIL random_cnt cyc=%0d got %0d want %0d",
                 i, underflow_cnt, m_ufcnt);
      end
`endif
    end
  endtask

  initial begin
    next_word = DW'($urandom);
    model_reset();
    test_reset();
    test_align();
    test_frame();
    test_underflow();
    test_sync_err();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
